// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter: round-robin arbiter sharing one DMA read port between two requesters.
// Latency: ready pulse and dma ctrl_valid one cycle after valid is sampled in IDLE; beat routing is combinational.
// Backpressure: ctrl held until dma_read_ctrl_ready; beats stall upstream outside DATA and follow the owner's ready inside it.
module dma_rd_arbiter (
  input  logic        clk,
  input  logic        rst_n,

  // requester 0
  input  logic        req0_ctrl_valid,
  output logic        req0_ctrl_ready,
  input  logic [31:0] req0_ctrl_index,
  input  logic [31:0] req0_ctrl_length,
  input  logic [2:0]  req0_ctrl_size,
  input  logic [5:0]  req0_ctrl_user,
  output logic        req0_chnl_valid,
  input  logic        req0_chnl_ready,
  output logic [63:0] req0_chnl_data,

  // requester 1
  input  logic        req1_ctrl_valid,
  output logic        req1_ctrl_ready,
  input  logic [31:0] req1_ctrl_index,
  input  logic [31:0] req1_ctrl_length,
  input  logic [2:0]  req1_ctrl_size,
  input  logic [5:0]  req1_ctrl_user,
  output logic        req1_chnl_valid,
  input  logic        req1_chnl_ready,
  output logic [63:0] req1_chnl_data,

  // downstream DMA control
  input  logic        dma_read_ctrl_ready,
  output logic        dma_read_ctrl_valid,
  output logic [31:0] dma_read_ctrl_data_index,
  output logic [31:0] dma_read_ctrl_data_length,
  output logic [2:0]  dma_read_ctrl_data_size,
  output logic [5:0]  dma_read_ctrl_data_user,

  // downstream DMA channel
  input  logic        dma_read_chnl_valid,
  output logic        dma_read_chnl_ready,
  input  logic [63:0] dma_read_chnl_data,

  // status
  output logic        grant_id,
  output logic        busy,
  output logic [31:0] debug
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CTRL = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state;
  logic        last_grant;
  logic [31:0] beat_cnt;

  logic        any_req;
  logic        winner;
  logic        beat_hs;
  logic        last_beat;

  // Round-robin pick: on a tie the requester that did not win last time goes first
  always_comb begin
    any_req = req0_ctrl_valid | req1_ctrl_valid;
    if (req0_ctrl_valid && req1_ctrl_valid) begin
      winner = ~last_grant;
    end else begin
      winner = req1_ctrl_valid;
    end
  end

  // Route beats to the current owner only while in DATA; everything else sees idle
  always_comb begin
    dma_read_chnl_ready = 1'b0;
    req0_chnl_valid     = 1'b0;
    req1_chnl_valid     = 1'b0;
    req0_chnl_data      = '0;
    req1_chnl_data      = '0;
    if (state == DATA) begin
      if (grant_id) begin
        dma_read_chnl_ready = req1_chnl_ready;
        req1_chnl_valid     = dma_read_chnl_valid;
        req1_chnl_data      = dma_read_chnl_data;
      end else begin
        dma_read_chnl_ready = req0_chnl_ready;
        req0_chnl_valid     = dma_read_chnl_valid;
        req0_chnl_data      = dma_read_chnl_data;
      end
    end
  end

  // Beat accounting helpers; length is never zero in DATA so length-1 cannot wrap there
  always_comb begin
    beat_hs   = (state == DATA) && dma_read_chnl_valid && dma_read_chnl_ready;
    last_beat = (beat_cnt == (dma_read_ctrl_data_length - 32'd1));
  end

  assign busy  = (state != IDLE);
  assign debug = {30'd0, state};

  // Arbitration FSM; every control output it drives is a register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= IDLE;
      last_grant                <= 1'b1;
      grant_id                  <= 1'b0;
      beat_cnt                  <= '0;
      req0_ctrl_ready           <= 1'b0;
      req1_ctrl_ready           <= 1'b0;
      dma_read_ctrl_valid       <= 1'b0;
      dma_read_ctrl_data_index  <= '0;
      dma_read_ctrl_data_length <= '0;
      dma_read_ctrl_data_size   <= '0;
      dma_read_ctrl_data_user   <= '0;
    end else begin
      // accept pulses last exactly one cycle
      req0_ctrl_ready <= 1'b0;
      req1_ctrl_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant          <= winner;
            grant_id            <= winner;
            req0_ctrl_ready     <= ~winner;
            req1_ctrl_ready     <= winner;
            dma_read_ctrl_valid <= 1'b1;
            if (winner) begin
              dma_read_ctrl_data_index  <= req1_ctrl_index;
              dma_read_ctrl_data_length <= req1_ctrl_length;
              dma_read_ctrl_data_size   <= req1_ctrl_size;
              dma_read_ctrl_data_user   <= req1_ctrl_user;
            end else begin
              dma_read_ctrl_data_index  <= req0_ctrl_index;
              dma_read_ctrl_data_length <= req0_ctrl_length;
              dma_read_ctrl_data_size   <= req0_ctrl_size;
              dma_read_ctrl_data_user   <= req0_ctrl_user;
            end
            state <= CTRL;
          end
        end
        CTRL: begin
          // fields stay frozen until the DMA engine takes the command
          if (dma_read_ctrl_ready) begin
            dma_read_ctrl_valid <= 1'b0;
            beat_cnt            <= '0;
            state               <= (dma_read_ctrl_data_length == 32'd0) ? IDLE : DATA;
          end
        end
        DATA: begin
          if (beat_hs) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dma_rd_arbiter.md
DMA_RD_ARBITER -- requirements
Module: dma_rd_arbiter

Interface
REQ-001 SHALL expose: clk input 1, rising-edge clock for all logic.
REQ-002 SHALL expose: rst_n input 1, reset; asynchronous, active-low.
REQ-003 SHALL expose, for each requester k in {0,1}: reqk_ctrl_valid input 1, read request pending.
REQ-004 SHALL expose, for each k: reqk_ctrl_ready output 1, one-cycle pulse, request accepted.
REQ-005 SHALL expose, for each k: reqk_ctrl_index input 32, read offset in beats.
REQ-006 SHALL expose, for each k: reqk_ctrl_length input 32, number of beats.
REQ-007 SHALL expose, for each k: reqk_ctrl_size input 3, beat size code.
REQ-008 SHALL expose, for each k: reqk_ctrl_user input 6, USER field.
REQ-009 SHALL expose, for each k: reqk_chnl_valid output 1, routed beat valid.
REQ-010 SHALL expose, for each k: reqk_chnl_ready input 1, requester ready for a beat.
REQ-011 SHALL expose, for each k: reqk_chnl_data output 64, routed beat.
REQ-012 SHALL expose the downstream DMA control group: dma_read_ctrl_ready input 1; dma_read_ctrl_valid output 1; dma_read_ctrl_data_index output 32; dma_read_ctrl_data_length output 32; dma_read_ctrl_data_size output 3; dma_read_ctrl_data_user output 6.
REQ-013 SHALL expose the downstream DMA channel group: dma_read_chnl_valid input 1; dma_read_chnl_ready output 1; dma_read_chnl_data input 64.
REQ-014 SHALL expose: grant_id output 1, owner of the current or last grant; busy output 1, high whenever state != IDLE.
REQ-015 SHALL expose: debug output 32, {30'd0, state}.

Function
REQ-016 SHALL implement FSM states IDLE=0, CTRL=1, DATA=2.
REQ-017 IDLE: SHALL grant when any reqk_ctrl_valid=1, with round-robin selection; if both are valid, the requester != last_grant wins.
REQ-018 Grant edge: SHALL latch the winner's index, length, size and user into dma_read_ctrl_data_*; set last_grant and grant_id; register a one-cycle reqk_ctrl_ready=1 to the winner only; set dma_read_ctrl_valid=1; go to CTRL.
REQ-019 Grant latency: ready pulse and dma_read_ctrl_valid SHALL both be high in the cycle after the edge that sampled valid.
REQ-020 CTRL: SHALL hold dma_read_ctrl_valid and all fields stable until dma_read_ctrl_ready=1 is sampled; then clear valid and clear beat_cnt.
REQ-021 CTRL exit: if latched length=0, SHALL go to IDLE; otherwise SHALL go to DATA.
REQ-022 DATA routing, combinational: dma_read_chnl_ready = req[grant]_chnl_ready; req[grant]_chnl_valid = dma_read_chnl_valid; req[grant]_chnl_data = dma_read_chnl_data.
REQ-023 DATA: the non-granted requester SHALL see chnl_valid=0.
REQ-024 Outside DATA: dma_read_chnl_ready and both reqk_chnl_valid SHALL be 0; beats presented early SHALL stall upstream and SHALL NOT be dropped.
REQ-025 Beats: each dma_read_chnl_valid & dma_read_chnl_ready cycle SHALL increment the 32-bit beat_cnt.
REQ-026 DATA exit: on the handshake with beat_cnt == length-1, SHALL go to IDLE the next edge.
REQ-027 Back-to-back: a new grant SHALL be possible in the first IDLE cycle after DATA ends, giving a 1-cycle minimum IDLE gap.
REQ-028 SHALL keep exactly one grant in flight; requests arriving during CTRL/DATA SHALL wait, with their valid held by the requester.
REQ-029 A requester deasserting ctrl_valid before its grant SHALL NOT be granted.
REQ-030 SHALL hold grant_id unchanged between grants.

Reset
REQ-031 On rst_n=0, at any time including mid-burst, SHALL asynchronously force: state=IDLE, all *_valid and *_ready outputs 0, beat_cnt=0, last_grant=1, grant_id=0, busy=0, dma_read_ctrl_data_* = 0.
REQ-032 First grant after reset with both requesters valid SHALL go to req0.

Verification
REQ-033 Single request: req0 (index 0x10, length 4, size 3'b011, user 0) -> req0_ctrl_ready pulse 1 cycle; ctrl_valid with same fields until ctrl_ready; 4 beats delivered to req0 only; back in IDLE one cycle after beat 4.
REQ-034 Contention: req0 and req1 valid from reset, length 2 each -> order req0, req1, req0 while both stay asserted; grant_id follows each grant.
REQ-035 Backpressure: dma_read_ctrl_ready low 5 cycles -> fields stable throughout; req1_chnl_ready toggling during DATA -> beat_cnt counts only handshakes, no beat lost or duplicated, data bit-exact.
REQ-036 Zero length: req1 length 0 -> sequence IDLE->CTRL->IDLE; no chnl_ready asserted; busy clear after ctrl handshake.
REQ-037 Early data: dma_read_chnl_valid high during CTRL -> dma_read_chnl_ready=0 until DATA entered.
REQ-038 Reset mid-burst: rst_n low after beat 2 of 8 -> all outputs 0 immediately; next request is granted normally with beat_cnt starting at 0.
